// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : snoop_bus_arbiter
//  Description : Sequencer and round-robin arbiter for the shared snooping bus
//                between cache1 (proc1), cache2 (proc2) and main memory. Grants
//                the bus to one cache at a time, broadcasts the requester's
//                9-bit word, then collects the response: a ReadHit from the
//                other cache or data from memory. A bounded wait aborts
//                with a timeout pulse.
//  Ports       : clock, reset (sync, active-high)
//                req_p1/req_p2       level bus requests
//                cache1_bus/cache2_bus/mem_data  9-bit words {msg,tag,value}
//                mem_valid           mem_data valid this cycle
//                gnt_p1/gnt_p2       bus grants (registered)
//                bus_out             word driven on shared bus (registered)
//                done/timeout        1-cycle completion / abort pulses
//                busy                sequencer not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module snoop_bus_arbiter #(
    parameter int TIMEOUT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_p1,
    input  logic       req_p2,
    input  logic [8:0] cache1_bus,
    input  logic [8:0] cache2_bus,
    input  logic [8:0] mem_data,
    input  logic       mem_valid,
    output logic       gnt_p1,
    output logic       gnt_p2,
    output logic [8:0] bus_out,
    output logic       done,
    output logic       busy,
    output logic       timeout
);

    localparam logic [1:0] C_READ_MISS  = 2'b01;
    localparam logic [1:0] C_READ_HIT   = 2'b10;
    localparam logic [1:0] C_WRITE_BACK = 2'b11;
    localparam logic       C_P1         = 1'b0;
    localparam logic       C_P2         = 1'b1;
    localparam logic [7:0] C_WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_ADDR  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_sel, w_sel_nxt;          // granted requester
    logic       r_last, w_last_nxt;        // last completed requester
    // Only msg and tag of the latched command are consulted later; the
    // value nibble reaches the bus directly when entering ADDR.
    logic [1:0] r_cmd_msg, w_cmd_msg_nxt;
    logic [2:0] r_cmd_tag, w_cmd_tag_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;

    logic       r_gnt_p1, r_gnt_p2, r_done, r_busy, r_timeout;
    logic [8:0] r_bus_out;
    logic       w_done_nxt, w_timeout_nxt;
    logic [8:0] w_bus_nxt;

    logic [8:0] w_sel_word;
    logic [8:0] w_other_word;
    logic       w_cache_hit;
    logic       w_mem_hit;

    // Memory response msg bits carry no information for the sequencer.
    logic       w_unused;
    assign w_unused = &{1'b0, mem_data[8:7]};

    assign w_sel_word   = (r_sel == C_P2) ? cache2_bus : cache1_bus;
    assign w_other_word = (r_sel == C_P2) ? cache1_bus : cache2_bus;
    assign w_cache_hit  = (w_other_word[8:7] == C_READ_HIT) &&
                          (w_other_word[6:4] == r_cmd_tag);
    assign w_mem_hit    = mem_valid && (mem_data[6:4] == r_cmd_tag);

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_last_nxt    = r_last;
        w_cmd_msg_nxt = r_cmd_msg;
        w_cmd_tag_nxt = r_cmd_tag;
        w_cnt_nxt     = r_cnt;
        w_bus_nxt     = '0;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_p1 && req_p2) begin
                    w_sel_nxt   = (r_last == C_P1) ? C_P2 : C_P1;
                    w_state_nxt = S_GRANT;
                end else if (req_p1) begin
                    w_sel_nxt   = C_P1;
                    w_state_nxt = S_GRANT;
                end else if (req_p2) begin
                    w_sel_nxt   = C_P2;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                w_cmd_msg_nxt = w_sel_word[8:7];
                w_cmd_tag_nxt = w_sel_word[6:4];
                w_bus_nxt     = w_sel_word;   // visible for the ADDR cycle
                w_state_nxt   = S_ADDR;
            end
            S_ADDR: begin
                if (r_cmd_msg == C_READ_MISS) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    // WriteBack completes here; 00 and ReadHit are NOPs.
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_WAIT: begin
                if (w_cache_hit) begin
                    w_bus_nxt   = w_other_word;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_mem_hit) begin
                    w_bus_nxt   = {C_READ_HIT, mem_data[6:0]};
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == C_WAIT_LAST) begin
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_last_nxt  = r_sel;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sel     <= C_P1;
            r_last    <= C_P2;   // proc1 wins the first tie
            r_cmd_msg <= '0;
            r_cmd_tag <= '0;
            r_cnt     <= '0;
            r_gnt_p1  <= 1'b0;
            r_gnt_p2  <= 1'b0;
            r_bus_out <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_last    <= w_last_nxt;
            r_cmd_msg <= w_cmd_msg_nxt;
            r_cmd_tag <= w_cmd_tag_nxt;
            r_cnt     <= w_cnt_nxt;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            r_gnt_p1  <= (w_state_nxt != S_IDLE) && (w_sel_nxt == C_P1);
            r_gnt_p2  <= (w_state_nxt != S_IDLE) && (w_sel_nxt == C_P2);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_bus_out <= w_bus_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt_p1  = r_gnt_p1;
    assign gnt_p2  = r_gnt_p2;
    assign bus_out = r_bus_out;
    assign done    = r_done;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snoop_bus_arbiter
//  Description : Directed self-checking bench for snoop_bus_arbiter.
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       req_p1, req_p2;
    logic [8:0] cache1_bus, cache2_bus, mem_data;
    logic       mem_valid;
    logic       gnt_p1, gnt_p2, done, busy, timeout;
    logic [8:0] bus_out;

    int checks = 0;
    int errors = 0;

    snoop_bus_arbiter #(.TIMEOUT(8)) dut (
        .clock      (clk),
        .reset      (rst),
        .req_p1     (req_p1),
        .req_p2     (req_p2),
        .cache1_bus (cache1_bus),
        .cache2_bus (cache2_bus),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid),
        .gnt_p1     (gnt_p1),
        .gnt_p2     (gnt_p2),
        .bus_out    (bus_out),
        .done       (done),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and land on the falling edge; grants must never overlap.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("gnt_exclusive", {8'd0, gnt_p1 & gnt_p2}, 9'd0);
    endtask

    // Full output vector {gnt_p1,gnt_p2,done,busy,timeout} plus bus_out.
    task automatic chk_out(input string tag, input logic [4:0] ctl, input logic [8:0] bus);
        chk({tag, "_ctl"}, {4'd0, gnt_p1, gnt_p2, done, busy, timeout}, {4'd0, ctl});
        chk({tag, "_bus"}, bus_out, bus);
    endtask

    initial begin
        rst = 1'b1; req_p1 = 1'b0; req_p2 = 1'b0;
        cache1_bus = '0; cache2_bus = '0; mem_data = '0; mem_valid = 1'b0;
        @(negedge clk);
        tick();
        chk_out("reset", 5'b00000, 9'd0);

        // 1: cache1 WriteBack
        rst = 1'b0; req_p1 = 1'b1; cache1_bus = 9'b11_010_0101;
        tick(); chk_out("wb_grant", 5'b10010, 9'd0);
        req_p1 = 1'b0;
        tick(); chk_out("wb_addr", 5'b10010, 9'b11_010_0101);
        tick(); chk_out("wb_done", 5'b10110, 9'd0);
        tick(); chk_out("wb_idle", 5'b00000, 9'd0);

        // 2: cache2 ReadMiss tag 3, answered by cache1; wrong tags ignored first
        req_p2 = 1'b1; cache2_bus = 9'b01_011_0000; cache1_bus = '0;
        tick(); chk_out("rm2_grant", 5'b01010, 9'd0);
        tick(); chk_out("rm2_addr", 5'b01010, 9'b01_011_0000);
        cache1_bus = 9'b10_010_0111; mem_valid = 1'b1; mem_data = 9'b01_001_1111;
        tick(); chk_out("rm2_wait0", 5'b01010, 9'd0);
        tick(); chk_out("rm2_wrongtag", 5'b01010, 9'd0);
        cache1_bus = 9'b10_011_0111; mem_valid = 1'b0; mem_data = '0;
        tick(); chk_out("rm2_hit", 5'b01110, 9'b10_011_0111);
        req_p2 = 1'b0; cache1_bus = '0; cache2_bus = '0;
        tick(); chk_out("rm2_idle", 5'b00000, 9'd0);

        // 3: cache2 ReadMiss tag 5, memory and cache1 hit together -> cache wins
        req_p2 = 1'b1; cache2_bus = 9'b01_101_0000;
        tick(); tick(); tick();
        chk_out("prio_wait", 5'b01010, 9'd0);
        mem_valid = 1'b1; mem_data = 9'b01_101_1001; cache1_bus = 9'b10_101_0010;
        tick(); chk_out("prio_done", 5'b01110, 9'b10_101_0010);
        req_p2 = 1'b0; mem_valid = 1'b0; mem_data = '0; cache1_bus = '0; cache2_bus = '0;
        tick();

        // 3b: cache1 ReadMiss tag 6, served by memory
        req_p1 = 1'b1; cache1_bus = 9'b01_110_0000;
        tick(); tick(); tick();
        mem_valid = 1'b1; mem_data = 9'b01_110_1011;
        tick(); chk_out("mem_done", 5'b10110, 9'b10_110_1011);
        req_p1 = 1'b0; mem_valid = 1'b0; mem_data = '0; cache1_bus = '0;
        tick();

        // 3c: msg 00 is a NOP request
        req_p2 = 1'b1; cache2_bus = 9'b00_100_0001;
        tick(); tick(); chk_out("nop_addr", 5'b01010, 9'b00_100_0001);
        tick(); chk_out("nop_done", 5'b01110, 9'd0);
        req_p2 = 1'b0; cache2_bus = '0;
        tick();

        // 4: both requesting from reset -> p1, p2, p1
        rst = 1'b1; tick(); rst = 1'b0;
        req_p1 = 1'b1; req_p2 = 1'b1;
        cache1_bus = 9'b11_001_0001; cache2_bus = 9'b11_010_0010;
        tick(); chk_out("rr_g1", 5'b10010, 9'd0);
        tick(); chk_out("rr_a1", 5'b10010, 9'b11_001_0001);
        tick(); chk_out("rr_d1", 5'b10110, 9'd0);
        tick(); chk_out("rr_i1", 5'b00000, 9'd0);
        tick(); chk_out("rr_g2", 5'b01010, 9'd0);
        tick(); chk_out("rr_a2", 5'b01010, 9'b11_010_0010);
        tick(); chk_out("rr_d2", 5'b01110, 9'd0);
        tick(); chk_out("rr_i2", 5'b00000, 9'd0);
        tick(); chk_out("rr_g3", 5'b10010, 9'd0);
        req_p1 = 1'b0; req_p2 = 1'b0;
        tick(); tick(); tick();
        chk_out("rr_end", 5'b00000, 9'd0);

        // 5: ReadMiss with no answer -> 8 wait cycles then timeout
        req_p1 = 1'b1; cache1_bus = 9'b01_111_0000; cache2_bus = '0;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out($sformatf("to_wait%0d", i), 5'b10010, 9'd0);
        end
        tick(); chk_out("to_done", 5'b10111, 9'd0);
        req_p1 = 1'b0;
        tick(); chk_out("to_idle", 5'b00000, 9'd0);

        // 6: reset during WAIT_RESP (last grant is proc1 at this point)
        req_p1 = 1'b1; cache1_bus = 9'b01_010_0000;
        tick(); tick(); tick(); tick();
        chk_out("rst_pre", 5'b10010, 9'd0);
        rst = 1'b1;
        tick(); chk_out("rst_mid", 5'b00000, 9'd0);
        rst = 1'b0; req_p2 = 1'b1;
        tick(); chk_out("rst_tie", 5'b10010, 9'd0);
        req_p1 = 1'b0; req_p2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
